adder_seq_ctrl: RTL

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

---
 rtl/adder_seq_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/adder_seq_ctrl.sv
// Sequential W-bit adder shared by two requesters. A single 4-bit ripple adder
// is reused one nibble per cycle; round-robin arbitration picks the requester.

module fourbitadder (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);
   always_comb begin
      logic       c;
      logic [3:0] s;
      // NOTE: blocking assignments inside always_comb; c must update in order as the ripple walks up.
      c = cin_i;
      s = '0;
      for (int i = 0; i < 4; i++) begin
         s[i] = a_i[i] ^ b_i[i] ^ c;
         c    = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
      end
      sum_o  = s;
      cout_o = c;
   end
endmodule

module adder_seq_ctrl #(
   parameter int NIB = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [4*NIB-1:0] a0,
   input  logic [4*NIB-1:0] b0,
   input  logic [4*NIB-1:0] a1,
   input  logic [4*NIB-1:0] b1,
   input  logic             cin0,
   input  logic             cin1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_id,
   output logic [4*NIB-1:0] out_sum,
   output logic             out_cout
);
   localparam int NW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [NW-1:0] LAST_NIB = NW'(NIB - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state_q, state_d;
   logic [NW-1:0]         nib_q, nib_d;
   logic                  carry_q, carry_d;
   logic [NIB-1:0][3:0]   a_q, a_d;
   logic [NIB-1:0][3:0]   b_q, b_d;
   logic [NIB-1:0][3:0]   work_q, work_d;
   logic [NIB-1:0][3:0]   sum_q, sum_d;
   logic                  cout_q, cout_d;
   logic                  id_q, id_d;
   logic                  last_q, last_d;

   logic [3:0]            add_sum;
   logic                  add_cout;
   logic                  win0, win1;

   fourbitadder u_add (
      .a_i    (a_q[nib_q]),
      .b_i    (b_q[nib_q]),
      .cin_i  (carry_q),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   // last_q names the requester served most recently; it loses a tie.
   assign win0 = req0 & (~req1 | last_q);
   assign win1 = req1 & (~req0 | ~last_q);

   assign gnt0      = (state_q == IDLE) & ~rst & win0;
   assign gnt1      = (state_q == IDLE) & ~rst & win1;
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_id    = id_q;

   always_comb begin
      // NOTE: every _d gets its hold value first so no path through the case infers a latch.
      state_d = state_q;
      nib_d   = nib_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      work_d  = work_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      id_d    = id_q;
      last_d  = last_q;

      case (state_q)
         IDLE: begin
            if (gnt0 | gnt1) begin
               a_d     = gnt1 ? a1 : a0;
               b_d     = gnt1 ? b1 : b0;
               carry_d = gnt1 ? cin1 : cin0;
               nib_d   = '0;
               last_d  = gnt1;
               state_d = RUN;
            end
         end
         RUN: begin
            work_d[nib_q] = add_sum;
            carry_d       = add_cout;
            nib_d         = nib_q + 1'b1;
            if (nib_q == LAST_NIB) begin
               // Published results change only here, so the previous result stays visible during RUN.
               nib_d   = '0;
               sum_d   = work_d;
               cout_d  = add_cout;
               id_d    = last_q;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         nib_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         nib_q   <= nib_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         work_q  <= work_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         id_q    <= id_d;
         last_q  <= last_d;
      end
   end
endmodule
